aud_src_arb: RTL

AUD_SRC_ARB -- requirements
Module: aud_src_arb

---
 rtl/aud_src_arb.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aud_src_arb.sv
// Two-source audio sample arbiter feeding an I2S generator: per-source staging
// slots, fixed/round-robin/mix/mute selection, grant reporting and underrun count.
module aud_src_arb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             aud_clk_i,
  input  logic             aud_rst_i,
  input  logic [1:0]       mode_i,
  input  logic [31:0]      s0_data_i,
  input  logic [31:0]      s1_data_i,
  input  logic             s0_valid_i,
  input  logic             s1_valid_i,
  output logic             s0_ready_o,
  output logic             s1_ready_o,
  output logic [31:0]      m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [1:0]       grant_o,
  output logic [CNT_W-1:0] underrun_cnt_o,
  input  logic             clr_cnt_i
);

  typedef enum logic [1:0] {
    MODE_FIXED = 2'b00,
    MODE_RR    = 2'b01,
    MODE_MIX   = 2'b10,
    MODE_MUTE  = 2'b11
  } mode_e;

  // Signed 16-bit add clamped to the 16-bit range.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {a[15], a} + {b[15], b};
    if (sum[16] != sum[15]) begin
      sat_add = sum[16] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_add = sum[15:0];
    end
  endfunction

  logic [1:0]       stg_v_r;
  logic [31:0]      stg0_d_r;
  logic [31:0]      stg1_d_r;
  mode_e            mode_r;
  logic             rr_last_r;
  logic [1:0]       grant_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       sel_s;
  logic [31:0]      data_s;
  logic             valid_s;
  logic [1:0]       consume_s;
  logic [1:0]       accept_s;
  logic             underrun_s;

  // Source selection and output sample formation from the registered mode.
  always_comb begin
    sel_s   = 2'b00;
    data_s  = 32'h0000_0000;
    valid_s = 1'b0;
    case (mode_r)
      MODE_FIXED: begin
        valid_s = |stg_v_r;
        if (stg_v_r[0]) begin
          sel_s  = 2'b01;
          data_s = stg0_d_r;
        end else if (stg_v_r[1]) begin
          sel_s  = 2'b10;
          data_s = stg1_d_r;
        end else begin
          sel_s  = 2'b00;
        end
      end
      MODE_RR: begin
        valid_s = |stg_v_r;
        // With both staged, rr_last names the source served last, so take the other.
        if (&stg_v_r) begin
          sel_s = rr_last_r ? 2'b01 : 2'b10;
        end else begin
          sel_s = stg_v_r;
        end
        if (sel_s[0]) begin
          data_s = stg0_d_r;
        end else if (sel_s[1]) begin
          data_s = stg1_d_r;
        end else begin
          data_s = 32'h0000_0000;
        end
      end
      MODE_MIX: begin
        valid_s = |stg_v_r;
        sel_s   = stg_v_r;
        if (&stg_v_r) begin
          data_s = {sat_add(stg0_d_r[31:16], stg1_d_r[31:16]),
                    sat_add(stg0_d_r[15:0],  stg1_d_r[15:0])};
        end else if (stg_v_r[0]) begin
          data_s = stg0_d_r;
        end else if (stg_v_r[1]) begin
          data_s = stg1_d_r;
        end else begin
          data_s = 32'h0000_0000;
        end
      end
      MODE_MUTE: begin
        valid_s = 1'b1;
        sel_s   = stg_v_r;
      end
      default: begin
        valid_s = 1'b0;
        sel_s   = 2'b00;
      end
    endcase
    if (aud_rst_i) begin
      valid_s = 1'b0;
      data_s  = 32'h0000_0000;
      sel_s   = 2'b00;
    end else begin
      valid_s = valid_s;
    end
  end

  assign consume_s  = sel_s & {2{m_ready_i & valid_s}};
  assign underrun_s = m_ready_i & ~valid_s & ~aud_rst_i;
  assign accept_s   = {s1_valid_i & s1_ready_o, s0_valid_i & s0_ready_o};

  assign s0_ready_o     = ~stg_v_r[0] & ~aud_rst_i;
  assign s1_ready_o     = ~stg_v_r[1] & ~aud_rst_i;
  assign m_valid_o      = valid_s;
  assign m_data_o       = valid_s ? data_s : 32'h0000_0000;
  assign grant_o        = grant_r;
  assign underrun_cnt_o = cnt_r;

  // Staging slots: fill on accept, empty on consume (never both for one slot).
  always_ff @(posedge aud_clk_i) begin
    if (aud_rst_i) begin
      stg_v_r  <= 2'b00;
      stg0_d_r <= 32'h0000_0000;
      stg1_d_r <= 32'h0000_0000;
    end else begin
      stg_v_r <= (stg_v_r & ~consume_s) | accept_s;
      if (accept_s[0]) stg0_d_r <= s0_data_i;
      if (accept_s[1]) stg1_d_r <= s1_data_i;
    end
  end

  // Mode and round-robin history; mode only moves on frame boundaries.
  always_ff @(posedge aud_clk_i) begin
    if (aud_rst_i) begin
      mode_r    <= mode_e'(mode_i);
      rr_last_r <= 1'b1;
    end else begin
      if (m_ready_i) mode_r <= mode_e'(mode_i);
      if ((mode_r == MODE_RR) && (|consume_s)) rr_last_r <= consume_s[1];
    end
  end

  // Grant report and saturating underrun counter.
  always_ff @(posedge aud_clk_i) begin
    if (aud_rst_i) begin
      grant_r <= 2'b00;
      cnt_r   <= '0;
    end else begin
      if (m_ready_i) grant_r <= consume_s;
      if (clr_cnt_i) begin
        cnt_r <= '0;
      end else if (underrun_s && !(&cnt_r)) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule
